// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU datapath and
// debug/program loader) and the shared unified memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_adr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  // Arbiter side: takes requests and memory read data, drives everything else.
  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    output mem_adr, mem_wdata, mem_we, busy, owner
  );

  // Environment side: requesters plus the memory itself.
  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    input  mem_adr, mem_wdata, mem_we, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory between the CPU datapath
// and the debug port. Each access is IDLE (grant) -> MEM_LAT ACCESS cycles ->
// one RESP cycle carrying the owner's ack pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // Counter only needs to reach MEM_LAT-1; keep at least one bit for MEM_LAT=1.
  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_served;
  logic              owner_q;
  logic              is_write;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic              any_req;
  logic              grant_dbg;
  logic              last_cycle;

  // Debug wins when it is the only requester, or on a tie when the CPU was
  // served last; otherwise the CPU gets the grant.
  assign any_req    = bus.cpu_req | bus.dbg_req;
  assign grant_dbg  = bus.dbg_req & (~bus.cpu_req | ~last_served);
  assign last_cycle = (cnt == CNT_LAST);

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: grant on any request, hold ACCESS for MEM_LAT cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (last_cycle) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the granted request, count latency, capture read data and
  // raise the owner's ack for the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      last_served <= 1'b1;
      owner_q     <= 1'b0;
      is_write    <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            adr_q       <= grant_dbg ? bus.dbg_adr   : bus.cpu_adr;
            wdata_q     <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            is_write    <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
            owner_q     <= grant_dbg;
            last_served <= grant_dbg;
            cnt         <= '0;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            if (!is_write) begin
              if (owner_q) dbg_rdata_q <= bus.mem_rdata;
              else         cpu_rdata_q <= bus.mem_rdata;
            end
            cpu_ack_q <= ~owner_q;
            dbg_ack_q <= owner_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: write strobe decoded from state so reset kills it immediately.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.mem_we    = (state == ACCESS) && last_cycle && is_write;
    bus.mem_adr   = adr_q;
    bus.mem_wdata = wdata_q;
    bus.owner     = owner_q;
    bus.cpu_ack   = cpu_ack_q;
    bus.dbg_ack   = dbg_ack_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dbg_rdata = dbg_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single accesses plus hand-written
// sequences for ties, back-to-back requests, mid-access reset and MEM_LAT=1.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          ack_cycle;
    logic        owner;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;
  int   we_cycle = 0;
  logic [31:0] we_adr = '0;
  logic [31:0] we_data = '0;
  exp_t cpu_q[$];
  exp_t dbg_q[$];
  vec_t vecs [9];

  logic [31:0] mem  [0:255];
  logic [31:0] mem1 [0:255];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memories: combinational read, written on mem_we, reloaded on reset.
  assign bus.mem_rdata  = mem[bus.mem_adr[7:0]];
  assign bus1.mem_rdata = mem1[bus1.mem_adr[7:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 32'h1000_0000 + i;
        mem1[i] <= 32'h2000_0000 + i;
      end
      mem[8'h10]  <= 32'hDEAD_BEEF;
      mem1[8'h44] <= 32'h0BAD_F00D;
    end else begin
      if (bus.mem_we)  mem[bus.mem_adr[7:0]]   <= bus.mem_wdata;
      if (bus1.mem_we) mem1[bus1.mem_adr[7:0]] <= bus1.mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any acks / write strobes seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.cpu_ack) begin
      if (cpu_q.size() == 0) checkOutput("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'd0);
      else begin
        e = cpu_q.pop_front();
        checkOutput("cpu_rdata", bus.cpu_rdata, e.rdata);
        checkOutput("cpu_ack_cycle", cyc, e.ack_cycle);
        checkOutput("cpu_owner", 32'(bus.owner), 32'(e.owner));
      end
    end
    if (bus.dbg_ack) begin
      if (dbg_q.size() == 0) checkOutput("dbg_ack_unexpected", 32'(bus.dbg_ack), 32'd0);
      else begin
        e = dbg_q.pop_front();
        checkOutput("dbg_rdata", bus.dbg_rdata, e.rdata);
        checkOutput("dbg_ack_cycle", cyc, e.ack_cycle);
        checkOutput("dbg_owner", 32'(bus.owner), 32'(e.owner));
      end
    end
    if (bus.mem_we) begin
      we_count++;
      we_cycle = cyc;
      we_adr   = bus.mem_adr;
      we_data  = bus.mem_wdata;
    end
  endtask

  task automatic expectAck(input logic port, input logic [31:0] rdata, input int ack_cycle);
    exp_t e;
    e.rdata     = rdata;
    e.ack_cycle = ack_cycle;
    e.owner     = port;
    if (port) dbg_q.push_back(e);
    else      cpu_q.push_back(e);
  endtask

  task automatic clearInputs();
    bus.cpu_req = 0;  bus.cpu_we = 0;  bus.cpu_adr = '0;  bus.cpu_wdata = '0;
    bus.dbg_req = 0;  bus.dbg_we = 0;  bus.dbg_adr = '0;  bus.dbg_wdata = '0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_adr = '0; bus1.cpu_wdata = '0;
    bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_adr = '0; bus1.dbg_wdata = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    cpu_q.delete();
    dbg_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One complete access on one port, starting from an IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    int   start;
    int   we_before;
    int   n;
    logic seen;
    we_before = we_count;
    if (v.port) begin
      bus.dbg_req = 1; bus.dbg_we = v.we; bus.dbg_adr = v.adr; bus.dbg_wdata = v.wdata;
    end else begin
      bus.cpu_req = 1; bus.cpu_we = v.we; bus.cpu_adr = v.adr; bus.cpu_wdata = v.wdata;
    end
    start = cyc;
    expectAck(v.port, v.exp_rdata, start + MEM_LAT + 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = v.port ? bus.dbg_ack : bus.cpu_ack;
    end
    checkOutput("ack_seen", 32'(seen), 32'd1);
    if (!seen) begin
      cpu_q.delete();
      dbg_q.delete();
    end
    bus.cpu_req = 0;
    bus.dbg_req = 0;
    checkOutput("mem_adr_latched", bus.mem_adr, v.adr);
    checkOutput("mem_we_pulses", we_count - we_before, v.we ? 32'd1 : 32'd0);
    if (v.we) begin
      checkOutput("mem_we_cycle", we_cycle, start + MEM_LAT);
      checkOutput("mem_we_adr", we_adr, v.adr);
      checkOutput("mem_we_data", we_data, v.wdata);
    end
    tick();
    checkOutput("rdata_held", v.port ? bus.dbg_rdata : bus.cpu_rdata, v.exp_rdata);
  endtask

  // Global time limit so a stuck DUT can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   n0;
    int   we_before;
    logic seen;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h20, 32'h1234,      32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h0000_1234};
    vecs[3] = '{1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h30, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h30, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b1, 32'hFF, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 1'b0, 32'hFF, 32'h0,         32'hA5A5_A5A5};

    rst = 1'b1;
    clearInputs();
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_busy",      32'(bus.busy),    32'd0);
    checkOutput("rst_owner",     32'(bus.owner),   32'd0);
    checkOutput("rst_cpu_ack",   32'(bus.cpu_ack), 32'd0);
    checkOutput("rst_dbg_ack",   32'(bus.dbg_ack), 32'd0);
    checkOutput("rst_mem_we",    32'(bus.mem_we),  32'd0);
    checkOutput("rst_mem_adr",   bus.mem_adr,      32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata,    32'd0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata,    32'd0);
    checkOutput("rst_dbg_rdata", bus.dbg_rdata,    32'd0);

    $display("[TB] single-access vector table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Tie right after reset: CPU first, then strict alternation while both hold.
    $display("[TB] simultaneous requests");
    doReset();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 32'h10;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_adr = 32'h30;
    n0 = cyc;
    expectAck(1'b0, 32'hDEAD_BEEF, n0 + 3);
    expectAck(1'b1, 32'h1000_0030, n0 + 7);
    expectAck(1'b0, 32'hDEAD_BEEF, n0 + 11);
    expectAck(1'b1, 32'h1000_0030, n0 + 15);
    while ((cpu_q.size() > 0 || dbg_q.size() > 0) && cyc < n0 + 25) tick();
    bus.cpu_req = 0;
    bus.dbg_req = 0;
    checkOutput("alt_pending", cpu_q.size() + dbg_q.size(), 32'd0);
    cpu_q.delete();
    dbg_q.delete();
    tick();
    tick();

    // CPU alone holding its request across three accesses.
    $display("[TB] back-to-back CPU reads");
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 32'h10;
    n0 = cyc;
    expectAck(1'b0, 32'hDEAD_BEEF, n0 + 3);
    expectAck(1'b0, 32'hDEAD_BEEF, n0 + 7);
    expectAck(1'b0, 32'hDEAD_BEEF, n0 + 11);
    while (cpu_q.size() > 0 && cyc < n0 + 20) tick();
    bus.cpu_req = 0;
    checkOutput("b2b_pending", cpu_q.size(), 32'd0);
    checkOutput("b2b_owner", 32'(bus.owner), 32'd0);
    cpu_q.delete();
    tick();
    tick();

    // Reset in the first ACCESS cycle of a debug write aborts it cleanly.
    $display("[TB] reset during access");
    doReset();
    we_before = we_count;
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_adr = 32'h40; bus.dbg_wdata = 32'h55AA;
    tick();
    checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.dbg_req = 0;
    #1;
    checkOutput("abort_busy",    32'(bus.busy),    32'd0);
    checkOutput("abort_mem_we",  32'(bus.mem_we),  32'd0);
    checkOutput("abort_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    checkOutput("abort_mem_adr", bus.mem_adr,      32'd0);
    checkOutput("abort_wdata",   bus.mem_wdata,    32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("abort_no_we", we_count - we_before, 32'd0);
    checkOutput("abort_idle",  32'(bus.busy), 32'd0);
    applyStimulus('{1'b1, 1'b1, 32'h40, 32'h55AA, 32'h0});
    applyStimulus('{1'b1, 1'b0, 32'h40, 32'h0,    32'h55AA});

    // Single-cycle memory build: ack three cycles into the access.
    $display("[TB] MEM_LAT=1 read");
    bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_adr = 32'h44;
    n0 = cyc;
    seen = 1'b0;
    while (!seen && cyc < n0 + 10) begin
      tick();
      seen = bus1.cpu_ack;
    end
    bus1.cpu_req = 0;
    checkOutput("lat1_ack_seen",  32'(seen), 32'd1);
    checkOutput("lat1_ack_cycle", cyc, n0 + 2);
    checkOutput("lat1_rdata",     bus1.cpu_rdata, 32'h0BAD_F00D);
    checkOutput("lat1_dbg_ack",   32'(bus1.dbg_ack), 32'd0);
    tick();
    checkOutput("lat1_rdata_held", bus1.cpu_rdata, 32'h0BAD_F00D);
    checkOutput("lat1_ack_pulse",  32'(bus1.cpu_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified instruction/data memory of the multi-cycle CPU between two requesters: the CPU datapath (fetch, load and store) and a debug/program-loader port. It supports memories with a configurable multi-cycle latency through a req/ack handshake, so the main controller can stall its state until ack. Arbitration is round-robin, so neither port starves.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access latency in cycles (>=1; 1 = existing single-cycle memory)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  CPU write enable (1 = store)
cpu_adr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU read data, valid while cpu_ack=1, held afterwards
cpu_ack  out  1  one-cycle completion pulse to CPU
dbg_req  in  1  debug request, level
dbg_we  in  1  debug write enable
dbg_adr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  debug read data, same rules as cpu_rdata
dbg_ack  out  1  one-cycle completion pulse to debug port
mem_adr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_adr is stable
busy  out  1  high in ACCESS and RESP
owner  out  1  0 = CPU, 1 = debug; port currently or last granted

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, last_served=debug (CPU wins the first tie), latency counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: sample the requests at the clock edge.
  - Only one req high: grant that port.
  - Both high: grant the port not equal to last_served.
  - On grant: latch adr/we/wdata into mem_adr/mem_wdata, set owner and last_served, counter=0, go to ACCESS.
  - No req: stay in IDLE; mem_adr/mem_wdata hold their values.
- ACCESS lasts exactly MEM_LAT cycles; the counter runs 0..MEM_LAT-1.
  - mem_we=1 only in the final ACCESS cycle (counter==MEM_LAT-1) and only for a write; a single pulse per write.
  - At the end of the final cycle:
    - Read: capture mem_rdata into owner's rdata register.
    - Write: rdata is unchanged.
  - Then go to RESP.
- RESP lasts one cycle: owner's ack=1 (registered); the other port's ack stays 0. Next state is IDLE.
- Latency: request first seen at the IDLE edge t -> ACCESS cycles t+1..t+MEM_LAT -> ack high in cycle t+MEM_LAT+1. Total is MEM_LAT+2 cycles per access, including IDLE.
- Requesters keep req, adr, we and wdata stable from assertion until ack. Changes to the granted port's inputs during ACCESS are ignored (the values are latched).
- A req still high in the IDLE cycle after ack counts as a new request. Back-to-back accesses by one port are legal; if the other port is waiting, it wins the tie.
- The non-granted port's request stays pending, with no ack, until it is granted.
- rdata registers hold their value until the next read completes for that same port.
- Simultaneous req rise and reset: reset dominates and no grant occurs.
- Reset asserted mid-ACCESS: the access is aborted. No ack is sent, mem_we drops immediately and the requester must re-issue.
- The counter width must hold MEM_LAT-1; MEM_LAT=1 means ACCESS lasts one cycle.

Test Plan:
- MEM_LAT=2, CPU read of adr 0x10, memory returns 0xDEADBEEF -> mem_adr=0x10 in 2 ACCESS cycles; cpu_ack in the 4th cycle after req; cpu_rdata=0xDEADBEEF held afterwards; dbg_ack stays 0.
- CPU write 0x20<-0x1234 -> mem_we high for exactly one cycle (2nd ACCESS cycle) with mem_wdata=0x1234; cpu_ack the following cycle; cpu_rdata unchanged.
- cpu_req and dbg_req both rise in the same cycle after reset -> CPU served first, debug second. With both held continuously, the grants alternate CPU, debug, CPU.
- CPU holds req across 3 accesses with no debug request -> 3 acks, each spaced MEM_LAT+2 cycles; owner stays 0.
- rst pulsed in the 1st ACCESS cycle of a debug write -> mem_we never asserts, no dbg_ack, outputs are 0, FSM is in IDLE. The re-issued request completes normally.
- MEM_LAT=1 build, single read -> ack 3 cycles after the req edge; data matches the combinational memory.
